// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for a multi-cycle ARM-subset datapath (DP / LDR / STR / B)
//   that shares one ALU and one memory. A Moore FSM sequences each
//   instruction, drives every mux select and write enable, decodes
//   ALUControl from the instruction fields, holds the NZCV flag register
//   and evaluates the condition code for conditional execution.
//
//   There are no valid/ready handshakes on this block. Every input is
//   sampled on every rising edge of clk, and the datapath is expected to
//   keep the instruction fields stable while an instruction runs.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Cond, Op, Funct, Rd instruction fields Instr[31:28], [27:26], [25:20], [15:12]
//   ALUFlags            NZCV produced by the ALU in the current cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc    datapath mux selects
//   ImmSrc, RegSrc      immediate / register-address selects, from Op
//   ALUControl          00 add, 01 sub, 10 and, 11 orr
//   Flags               current NZCV register
//   State               FSM state, exposed for checkers
module multicycle_controller #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags,
    output logic [3:0] State
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXECR  = 4'd6;
    localparam logic [3:0] EXECI  = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;

    logic [3:0] state, next_state, out_state;
    logic [3:0] flags_q;
    logic       condexr, condex;

    logic [3:0] cmd;
    logic       fn_i, fn_s;
    logic       is_cmp, is_arith, cmd_known, dp_writes;
    logic [1:0] dp_alu;
    logic       flagw_nz, flagw_cv;
    logic       rd_pc;
    logic       n_f, z_f, c_f, v_f;

    assign fn_i  = Funct[5];
    assign cmd   = Funct[4:1];
    assign fn_s  = Funct[0];
    assign rd_pc = (Rd == 4'd15);

    // cmd decode: unknown commands compute an add but never write back.
    always_comb begin
        dp_alu    = 2'b00;
        cmd_known = 1'b1;
        is_cmp    = 1'b0;
        is_arith  = 1'b0;
        case (cmd)
            4'b0100: begin dp_alu = 2'b00; is_arith = 1'b1; end
            4'b0010: begin dp_alu = 2'b01; is_arith = 1'b1; end
            4'b0000: dp_alu = 2'b10;
            4'b1100: dp_alu = 2'b11;
            4'b1010: begin dp_alu = 2'b01; is_arith = 1'b1; is_cmp = 1'b1; end
            default: cmd_known = 1'b0;
        endcase
    end

    assign dp_writes = cmd_known & ~is_cmp;
    // CMP always sets flags even when its S bit is clear.
    assign flagw_nz  = fn_s | is_cmp;
    assign flagw_cv  = flagw_nz & is_arith;

    assign n_f = flags_q[3];
    assign z_f = flags_q[2];
    assign c_f = flags_q[1];
    assign v_f = flags_q[0];

    always_comb begin
        case (Cond)
            4'b0000: condex = z_f;
            4'b0001: condex = ~z_f;
            4'b0010: condex = c_f;
            4'b0011: condex = ~c_f;
            4'b0100: condex = n_f;
            4'b0101: condex = ~n_f;
            4'b0110: condex = v_f;
            4'b0111: condex = ~v_f;
            4'b1000: condex = c_f & ~z_f;
            4'b1001: condex = ~c_f | z_f;
            4'b1010: condex = (n_f == v_f);
            4'b1011: condex = (n_f != v_f);
            4'b1100: condex = ~z_f & (n_f == v_f);
            4'b1101: condex = z_f | (n_f != v_f);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_comb begin
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   next_state = MEMADR;
                    2'b00:   next_state = fn_i ? EXECI : EXECR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            MEMADR: next_state = fn_s ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            flags_q <= FLAG_RESET;
            condexr <= 1'b0;
        end else begin
            state <= next_state;
            // The condition is frozen on pre-instruction flags.
            if (state == DECODE) begin
                condexr <= condex;
            end
            if (((state == EXECR) || (state == EXECI)) && condexr) begin
                if (flagw_nz) flags_q[3:2] <= ALUFlags[3:2];
                if (flagw_cv) flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // While reset is held the selects show the FETCH decode but all
    // write enables stay low, so an abandoned instruction writes nothing.
    assign out_state = reset ? FETCH : state;

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (out_state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = condexr & ~rd_pc;
                PCWrite   = condexr & rd_pc;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = condexr;
            end
            EXECR: ALUControl = dp_alu;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
            end
            ALUWB: begin
                RegWrite = condexr & dp_writes & ~rd_pc;
                PCWrite  = condexr & dp_writes & rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = condexr;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign Flags  = flags_q;
    assign State  = state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] Flags, State;

    multicycle_controller #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] exp_q[$];
    logic [3:0]  m_flags;

    logic [23:0] dut_vec;
    assign dut_vec = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ALUControl, Flags, ImmSrc, RegSrc};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h required=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: architectural meaning of each instruction class
    // turned into a per-cycle list of expected outputs.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (c[0]) ? !base : base;
    endfunction

    function automatic logic [23:0] mk(input logic [3:0] st, input logic pcw, input logic irw,
                                        input logic rw, input logic mw, input logic adr,
                                        input logic asa, input logic [1:0] asb,
                                        input logic [1:0] rs, input logic [1:0] alc);
        logic [1:0] rsrc;
        rsrc = {(Op == 2'b01), (Op == 2'b10)};
        return {st, pcw, irw, rw, mw, adr, asa, asb, rs, alc, m_flags, Op, rsrc};
    endfunction

    task automatic model_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                               input logic [3:0] rd, input logic [3:0] af);
        logic cx, known, cmp, arith, wr, setf;
        logic [1:0] alc;
        cx = cond_holds(c, m_flags);
        exp_q.push_back(mk(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        exp_q.push_back(mk(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00));
        case (op)
            2'b00: begin
                known = 1; cmp = 0; arith = 0; alc = 2'b00;
                case (fn[4:1])
                    4'b0100: arith = 1;
                    4'b0010: begin alc = 2'b01; arith = 1; end
                    4'b0000: alc = 2'b10;
                    4'b1100: alc = 2'b11;
                    4'b1010: begin alc = 2'b01; arith = 1; cmp = 1; end
                    default: known = 0;
                endcase
                wr   = known && !cmp;
                setf = fn[0] || cmp;
                exp_q.push_back(mk(fn[5] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0,
                                   fn[5] ? 2'b01 : 2'b00, 2'b00, alc));
                if (cx && setf) begin
                    m_flags[3:2] = af[3:2];
                    if (arith) m_flags[1:0] = af[1:0];
                end
                exp_q.push_back(mk(4'd8, cx && wr && rd == 15, 0, cx && wr && rd != 15, 0,
                                   0, 0, 2'b00, 2'b00, 2'b00));
            end
            2'b01: begin
                exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00));
                if (fn[0]) begin
                    exp_q.push_back(mk(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
                    exp_q.push_back(mk(4'd4, cx && rd == 15, 0, cx && rd != 15, 0,
                                       0, 0, 2'b00, 2'b01, 2'b00));
                end else begin
                    exp_q.push_back(mk(4'd5, 0, 0, 0, cx, 1, 0, 2'b00, 2'b00, 2'b00));
                end
            end
            2'b10: exp_q.push_back(mk(4'd9, cx, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00));
            default: ;
        endcase
    endtask

    // Driver: entered #1 after the edge that put the DUT in FETCH; returns
    // #1 after the edge that brings it back to FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                             input logic [3:0] rd, input logic [3:0] af, input bit chk,
                             input int exp_len, input logic [2:0] exp_wb,
                             input logic [3:0] exp_flags);
        int n;
        bit done;
        logic [2:0] last_wb;
        logic [23:0] e;
        Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
        model_instr(c, op, fn, rd, af);
        n = 0; done = 0; last_wb = 3'b000;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check("cycle_extra", {28'd0, State}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("cycle_outputs", {8'd0, dut_vec}, {8'd0, e});
            end
            last_wb = {PCWrite, RegWrite, MemWrite};
            @(posedge clk); #1;
            n++;
            if (State == 4'd0) done = 1;
            else if (n >= 10) begin
                check("timeout", n, 0);
                done = 1;
            end
        end
        if (exp_q.size() != 0) begin
            check("cycles_missing", exp_q.size(), 0);
            exp_q.delete();
        end
        if (chk) begin
            check("latency", n, exp_len);
            check("last_wb", {29'd0, last_wb}, {29'd0, exp_wb});
            check("flags_after", {28'd0, Flags}, {28'd0, exp_flags});
        end
    endtask

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] aluf;
        int         len;
        logic [2:0] wb;      // {PCWrite, RegWrite, MemWrite} in last cycle
        logic [3:0] flags;   // Flags after the instruction
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{4'hE, 2'b00, 6'b101000, 4'd2,  4'b1111, 4, 3'b010, 4'b0000}; // ADD #imm
        vecs[1]  = '{4'hE, 2'b00, 6'b000101, 4'd3,  4'b0110, 4, 3'b010, 4'b0110}; // SUBS
        vecs[2]  = '{4'h0, 2'b00, 6'b001000, 4'd4,  4'b0000, 4, 3'b010, 4'b0110}; // ADDEQ
        vecs[3]  = '{4'h1, 2'b00, 6'b001000, 4'd4,  4'b0000, 4, 3'b000, 4'b0110}; // ADDNE
        vecs[4]  = '{4'hE, 2'b01, 6'b011001, 4'd5,  4'b0000, 5, 3'b010, 4'b0110}; // LDR
        vecs[5]  = '{4'hE, 2'b01, 6'b011000, 4'd5,  4'b0000, 4, 3'b001, 4'b0110}; // STR
        vecs[6]  = '{4'hE, 2'b10, 6'b101000, 4'd0,  4'b0000, 3, 3'b100, 4'b0110}; // B
        vecs[7]  = '{4'hE, 2'b00, 6'b010100, 4'd0,  4'b0000, 4, 3'b000, 4'b0000}; // CMP
        vecs[8]  = '{4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 3, 3'b000, 4'b0000}; // BEQ, Z=0
        vecs[9]  = '{4'hE, 2'b11, 6'b000000, 4'd0,  4'b0000, 2, 3'b000, 4'b0000}; // undefined
        vecs[10] = '{4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, 4, 3'b100, 4'b0000}; // ADD PC
        vecs[11] = '{4'hE, 2'b00, 6'b000001, 4'd6,  4'b1011, 4, 3'b010, 4'b1000}; // ANDS
        vecs[12] = '{4'hE, 2'b00, 6'b011110, 4'd6,  4'b0101, 4, 3'b000, 4'b1000}; // bad cmd
        vecs[13] = '{4'hF, 2'b00, 6'b111000, 4'd7,  4'b0000, 4, 3'b000, 4'b1000}; // ORR never
        vecs[14] = '{4'hE, 2'b01, 6'b000001, 4'd15, 4'b0000, 5, 3'b100, 4'b1000}; // LDR PC
    end

    initial begin
        reset = 1'b1; Cond = 4'hE; Op = 2'b11; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
        m_flags = 4'b0000;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) check("rst_state", {28'd0, State}, 32'd0);
            check("rst_wen", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", {28'd0, State}, 32'd0);
        check("post_rst_flags", {28'd0, Flags}, 32'd0);
        check("post_rst_pc_ir", {30'd0, PCWrite, IRWrite}, 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_decode", {28'd0, State}, 32'd1);
        @(posedge clk); #1;
        check("undef_back_fetch", {28'd0, State}, 32'd0);

        // table-driven directed vectors
        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].aluf,
                      1'b1, vecs[i].len, vecs[i].wb, vecs[i].flags);
        end

        // reset asserted during MEMWR of a STR
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd1; ALUFlags = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("str_pre_state", {28'd0, State}, (i == 2) ? 32'd2 : i);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_memwr_state", {28'd0, State}, 32'd5);
        check("rst_memwr_wen", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        check("rst_memwr_sel", {26'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 32'b011010);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_memwr_next", {28'd0, State}, 32'd0);
        check("rst_memwr_flags", {28'd0, Flags}, 32'd0);
        m_flags = 4'b0000;

        // randomized instructions against the reference model
        for (int i = 0; i < 60; i++) begin
            run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'b0, 0, 3'b000, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit that sequences a shared-ALU, shared-memory ARM-subset datapath (DP / LDR / STR / B) through a multi-cycle state machine.
- Drives every datapath mux select and write enable, and derives ALUControl from the instruction fields.
- Holds the NZCV flag register and evaluates the condition code for conditional execution.
- Sits beside the datapath inside TOP; replaces single-cycle decode.

Parameters:
- FLAG_RESET, 4'b0000, reset value of the NZCV register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: I=Funct[5], cmd=Funct[4:1], S/L=Funct[0].
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  NZCV from the ALU in the current cycle.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  data memory write enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  1  0=RD1, 1=PC.
- ALUSrcB  out  2  00=RD2, 01=Ext imm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr.
- Flags  out  4  current NZCV register.
- State  out  4  FSM state encoding, for verification.

Behaviour:
- Clock, reset and write gating:
  - One clock (clk). Reset is synchronous and active-high (reset): at the rising edge with reset=1, State=FETCH(0), Flags=FLAG_RESET, CondExR=0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Selects follow the FETCH decode.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10-15 go to FETCH on the next edge with no writes.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 & I=0→EXECR; Op=00 & I=1→EXECI; Op=10→BRANCH; Op=11→FETCH (undefined instruction, no side effects).
  - MEMADR: L=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH. MEMWR→FETCH.
  - EXECR→ALUWB, EXECI→ALUWB, ALUWB→FETCH.
  - BRANCH→FETCH.
- Latency per instruction: DP 4 cycles, LDR 5, STR 4, B 3, undefined 2.
- Moore outputs (unlisted outputs are 0; ALUControl is add unless stated):
  - FETCH: AdrSrc0, IRWrite1, ALUSrcA1, ALUSrcB10, ResultSrc10, PCWrite1 (unconditional).
  - DECODE: ALUSrcA1, ALUSrcB10, ResultSrc10.
  - MEMADR: ALUSrcA0, ALUSrcB01.
  - MEMRD: AdrSrc1, ResultSrc00.
  - MEMWB: ResultSrc01, RegWrite=CondExR.
  - MEMWR: AdrSrc1, MemWrite=CondExR.
  - EXECR: ALUSrcB00, ALUControl from cmd.
  - EXECI: ALUSrcB01, ALUControl from cmd.
  - ALUWB: ResultSrc00, RegWrite=CondExR & not CMP.
  - BRANCH: ALUSrcA0, ALUSrcB01, ResultSrc10, PCWrite=CondExR.
- Writes to PC via Rd: in MEMWB/ALUWB with Rd=15, PCWrite=CondExR and RegWrite=0.
- cmd decode:
  - 0100 ADD→00, 0010 SUB→01, 0000 AND→10, 1100 ORR→11, 1010 CMP→01 with no register write.
  - Any other cmd→00 with RegWrite suppressed.
- Flag write enables:
  - FlagW[1] (N,Z) = S.
  - FlagW[0] (C,V) = S & cmd∈{ADD, SUB, CMP}.
  - CMP forces S=1.
- Flag update: at the edge leaving EXECR/EXECI, if CondExR=1, the enabled flag fields load from ALUFlags. No update in any other state.
- Condition evaluation:
  - CondEx is evaluated combinationally from Cond and the Flags register.
  - Codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1110→1; 1111→0.
  - CondExR latches CondEx at the edge leaving DECODE. The condition is therefore evaluated on pre-instruction flags.
  - A flag update in EXECR/EXECI does not alter CondExR for the same instruction's writeback.
- ImmSrc and RegSrc are combinational from Op in every state.
- Reset mid-instruction: the instruction is abandoned, there are no writes in the reset cycle, and the next cycle is FETCH.

Test Plan:
- Reset held 3 cycles, then released → State=0, Flags=0000, PCWrite=IRWrite=1 in the first post-reset cycle; State sequence 0→1 follows.
- ADD R2,R0,#5 (Cond=1110, Op=00, Funct=101000) → States 0,1,7,8,0; ALUControl=00 in EXECI; RegWrite=1 only in ALUWB; Flags unchanged.
- SUBS with ALUFlags=0110 in EXECR → Flags=0110 after EXECR. A following ADDEQ (Cond=0000) has RegWrite=1 in ALUWB. A following ADDNE has RegWrite=0.
- LDR (Op=01, L=1) → States 0,1,2,3,4,0; AdrSrc=1 in MEMRD; ResultSrc=01 with RegWrite=1 in MEMWB. STR (L=0) → MemWrite=1 only in MEMWR, 4 cycles total.
- B with Cond=1110 → States 0,1,9,0; PCWrite=1 in BRANCH. BEQ with Z=0 → PCWrite=0 in BRANCH.
- Op=11 → States 0,1,0, no write enables asserted. reset=1 asserted during MEMWR → MemWrite=0 that cycle, State=0 next.
